// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared constants and types for the stream_mux_rr block.
//   DEFAULT_N / DEFAULT_W : default channel count and per-channel data width
//   MODE_RR / MODE_FIXED  : encoding of the top-level mode input
//   lock_state_e          : packet-lock state, used when STREAM_MUX_PKT_LOCK_EN is defined
package stream_mux_pkg;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 4;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Grants the first asserted request at or
// after the pointer, scanning upward modulo N. Fixed selection is obtained by
// the caller masking the request vector down to a single channel.
//   req_i   [N-1:0]  request vector
//   ptr_i   [SW-1:0] priority pointer (must be < N)
//   en_i             grant enable; no grant when low
//   grant_o [N-1:0]  one-hot grant
//   idx_o   [SW-1:0] index of granted channel (0 when no grant)
//   any_o            a grant was issued
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [SW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    c       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (en_i && !any_o && req_i[c]) begin
        any_o      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = SW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-input stream multiplexer with a single registered output stage.
// Arbitration is round-robin (mode = MODE_RR) or a fixed channel (mode = MODE_FIXED, sel).
// Optional packet lock: define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last;
// a grant then stays on its channel until a beat with in_last transfers.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready [N] per-channel handshake; in_data [N*W], channel i at [i*W +: W]
//   mode, sel             arbitration mode and fixed channel index
//   out_valid/out_ready   output handshake; out_data [W], out_chan [SW]
//   dbg_ptr [SW]          current round-robin pointer (debug)
//   dbg_lock              packet-lock state (debug, lock build only)
// Handshake: a beat moves when valid and ready are both high at a rising clk edge.
// in_ready never depends on in_valid of the same channel through anything but arbitration,
// and it is only high while the output register can accept (empty or draining this cycle).
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int W  = DEFAULT_W,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_valid,
  input  logic [N*W-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]  in_last,
  output logic          out_last,
  output logic          dbg_lock,
`endif
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_chan,
  input  logic          out_ready,
  output logic [SW-1:0] dbg_ptr
);

  localparam logic [N-1:0] ONE = N'(1);

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_chan_q;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          accept_ok;
  logic [N-1:0]  fixed_mask;
  logic [N-1:0]  req_base;
  logic [N-1:0]  req;
  logic          upd_mode;
  logic [N-1:0]  gnt;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic [W-1:0]  gnt_data;

  assign accept_ok = ~out_valid_q | out_ready;

  // An out-of-range sel (N not a power of two) leaves the mask empty: no grant.
  always_comb begin
    fixed_mask = '0;
    if (int'(sel) < N) fixed_mask = ONE << sel;
    req_base = (mode == MODE_FIXED) ? (in_valid & fixed_mask) : in_valid;
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_e   lk_state_q, lk_state_d;
  logic [SW-1:0] lk_chan_q, lk_chan_d;
  logic          lk_mode_q, lk_mode_d;
  logic          out_last_q;

  // While locked, the live mode/sel are ignored and the pointer follows the
  // mode that was in force when the packet started.
  always_comb begin
    req      = req_base;
    upd_mode = mode;
    if (lk_state_q == LK_HELD) begin
      req      = in_valid & (ONE << lk_chan_q);
      upd_mode = lk_mode_q;
    end
  end

  always_comb begin
    lk_state_d = lk_state_q;
    lk_chan_d  = lk_chan_q;
    lk_mode_d  = lk_mode_q;
    if (gnt_any) begin
      if (in_last[gnt_idx]) begin
        lk_state_d = LK_OPEN;
      end else begin
        lk_state_d = LK_HELD;
        lk_chan_d  = gnt_idx;
        lk_mode_d  = upd_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_state_q <= LK_OPEN;
      lk_chan_q  <= '0;
      lk_mode_q  <= MODE_RR;
      out_last_q <= 1'b0;
    end else begin
      lk_state_q <= lk_state_d;
      lk_chan_q  <= lk_chan_d;
      lk_mode_q  <= lk_mode_d;
      if (gnt_any) out_last_q <= in_last[gnt_idx];
    end
  end

  assign out_last = out_last_q;
  assign dbg_lock = (lk_state_q == LK_HELD);
`else
  assign req      = req_base;
  assign upd_mode = mode;
`endif

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .en_i    (accept_ok),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign gnt_data = in_data[gnt_idx*W +: W];

  // Pointer only advances on a round-robin transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any && upd_mode == MODE_RR) begin
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gnt_data;
        out_chan_q  <= gnt_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      ptr_q <= ptr_d;
    end
  end

  // Gate with rst_n so in_ready is zero for the whole reset interval.
  assign in_ready  = gnt & {N{rst_n}};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Directed and randomized stimulus for stream_mux_rr (N=4, W=4) with a
// reference model and an expected-beat queue. Define STREAM_MUX_PKT_LOCK_EN
// to also exercise the packet-lock variant.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_ready;
  logic [SW-1:0] dbg_ptr;
  logic [N-1:0]  lastv;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          out_last;
  logic          dbg_lock;
`endif

  stream_mux_rr #(.N(N), .W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (lastv),
    .out_last  (out_last),
    .dbg_lock  (dbg_lock),
`endif
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_chk  = 0;
  int n_fail = 0;

  logic [SW+W-1:0] exp_q[$];
  logic [SW+W-1:0] got_q[$];
  logic            mdl_valid;
  logic [SW-1:0]   mdl_ptr;
  logic            mdl_locked;
  logic [SW-1:0]   mdl_lock_chan;
  logic            mdl_lock_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input logic m, input logic [SW-1:0] s,
                                     input logic [SW-1:0] p, input logic lk, input logic [SW-1:0] lc);
    int c;
    if (lk) return v[lc] ? int'(lc) : -1;
    if (m) return v[s] ? int'(s) : -1;
    for (int i = 0; i < N; i++) begin
      c = (int'(p) + i) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_valid     = 1'b0;
    mdl_ptr       = '0;
    mdl_locked    = 1'b0;
    mdl_lock_chan = '0;
    mdl_lock_mode = 1'b0;
  endtask

  // Inputs are already driven (at posedge+1). Checks outputs, scores the
  // cycle in the model, then advances to the next posedge+1.
  task automatic cycle();
    int              g;
    logic            acc;
    logic            um;
    logic [SW+W-1:0] head;
    logic [N-1:0]    exp_rdy;
    #1;
    acc     = !mdl_valid || out_ready;
    g       = acc ? model_grant(in_valid, mode, sel, mdl_ptr, mdl_locked, mdl_lock_chan) : -1;
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, mdl_valid);
    chk("ptr", dbg_ptr, mdl_ptr);
    if (mdl_valid) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
      end
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("out_chan", out_chan, head[W +: SW]);
        chk("out_data", out_data, head[W-1:0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          got_q.push_back({out_chan, out_data});
        end
      end
    end
    if (mdl_valid && out_ready) mdl_valid = 1'b0;
    if (g >= 0) begin
      um = mdl_locked ? mdl_lock_mode : mode;
      exp_q.push_back({SW'(g), in_data[g*W +: W]});
      mdl_valid = 1'b1;
      if (um == 1'b0) mdl_ptr = SW'((g + 1) % N);
      if (lastv[g]) begin
        mdl_locked = 1'b0;
      end else begin
        mdl_locked    = 1'b1;
        mdl_lock_chan = SW'(g);
        mdl_lock_mode = um;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_abcd();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(4'hA + i);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [SW+W-1:0] exp_rr;
    rst_n     = 1'b0;
    in_valid  = '1;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    lastv     = '1;
    set_data_abcd();
    model_reset();

    // Reset: everything quiet even with all channels requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_out_chan", out_chan, 2'd0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_ptr", dbg_ptr, 2'd0);
    rst_n = 1'b1;

    // Round-robin fairness: 0,1,2,3,0 with data A,B,C,D,A, one per cycle.
    got_q.delete();
    repeat (6) cycle();
    chk("rr_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      exp_rr = {SW'(i % 4), W'(4'hA + (i % 4))};
      if (i < got_q.size()) chk("rr_seq", got_q[i], exp_rr);
    end

    // Backpressure: held beat stable, no in_ready, then resume without loss.
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Fixed select on channel 2, then sel switched to 0 under a held beat.
    mode = 1'b1;
    sel  = 2'd2;
    repeat (3) cycle();
    out_ready = 1'b0;
    cycle();
    sel = 2'd0;
    repeat (2) cycle();
    chk("fixed_held_chan", out_chan, 2'd2);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Sparse requests: pointer to 1 via channel 0, then wrap-around to 0 again.
    mode     = 1'b0;
    in_valid = 4'b0000;
    repeat (2) cycle();
    in_valid = 4'b0001;
    cycle();
    in_valid = 4'b0000;
    repeat (2) cycle();
    chk("sparse_ptr_before", dbg_ptr, 2'd1);
    chk("sparse_idle_valid", out_valid, 1'b0);
    in_valid = 4'b0001;
    cycle();
    chk("sparse_chan_wrap", out_chan, 2'd0);
    chk("sparse_ptr_after", dbg_ptr, 2'd1);
    in_valid = 4'b1000;
    repeat (2) cycle();

    // Randomized traffic.
    for (int k = 0; k < 80; k++) begin
      in_valid  = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 4) == 0);
      sel       = SW'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom_range(0, 15));
      cycle();
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: channel 1 three-beat packet while channel 2 waits.
    mode      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b0000;
    lastv     = '1;
    repeat (2) cycle();
    set_data_abcd();
    got_q.delete();
    in_valid = 4'b0010;
    lastv    = 4'b0000;
    cycle();
    in_valid = 4'b0110;
    cycle();
    lastv = 4'b0010;
    cycle();
    lastv = '1;
    cycle();
    in_valid = 4'b0000;
    cycle();
    chk("lock_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) chk("lock_seq", got_q[i][W +: SW], (i < 3) ? 2'd1 : 2'd2);
    end
`endif

    // Reset mid-transfer: held beat discarded, restart from pointer 0.
    set_data_abcd();
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 4'b0000);
    chk("midrst_ptr", dbg_ptr, 2'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0110;
    cycle();
    chk("post_rst_chan", out_chan, 2'd1);
    chk("post_rst_data", out_data, 4'hB);
    in_valid = 4'b0000;
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
